// File: rtl/hazard_pkg.sv
// Shared hazard-timing constants for decode and the hazard scoreboard.
// Tuse is the stage distance before an operand is consumed; Tnew is the distance before a result is forwardable.
package hazard_pkg;

  localparam int HZ_TW = 3;
  localparam int HZ_XW = 6;

  localparam logic [HZ_TW-1:0] TUSE_BR  = 3'd0;
  localparam logic [HZ_TW-1:0] TUSE_ALU = 3'd1;
  localparam logic [HZ_TW-1:0] TUSE_ST  = 3'd2;

  localparam logic [HZ_TW-1:0] TNEW_ALU  = 3'd2;
  localparam logic [HZ_TW-1:0] TNEW_LD   = 3'd3;
  localparam logic [HZ_TW-1:0] TNEW_LWLR = 3'd4;

  localparam logic [HZ_XW-1:0] XALU_MUL_LAT = 6'd5;
  localparam logic [HZ_XW-1:0] XALU_DIV_LAT = 6'd32;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: the decoded instruction's operand/result timing plus the stall/issue reply.
interface hazard_scoreboard_if #(
  parameter int RW   = 5,
  parameter int NSRC = 2,
  parameter int TW   = 3,
  parameter int XW   = 6
);
  logic                 id_valid;
  logic [NSRC*RW-1:0]   id_src_reg;
  logic [NSRC-1:0]      id_src_need;
  logic [NSRC*TW-1:0]   id_src_tuse;
  logic                 id_dst_we;
  logic [RW-1:0]        id_dst_reg;
  logic [TW-1:0]        id_dst_tnew;
  logic                 id_hilo_use;
  logic                 id_xalu_start;
  logic [XW-1:0]        id_xalu_lat;
  logic                 stall;
  logic                 issue;

  modport master (
    output id_valid, id_src_reg, id_src_need, id_src_tuse, id_dst_we, id_dst_reg,
           id_dst_tnew, id_hilo_use, id_xalu_start, id_xalu_lat,
    input  stall, issue
  );

  modport slave (
    input  id_valid, id_src_reg, id_src_need, id_src_tuse, id_dst_we, id_dst_reg,
           id_dst_tnew, id_hilo_use, id_xalu_start, id_xalu_lat,
    output stall, issue
  );
endinterface

// File: rtl/hazard_sb_cnt.sv
// One scoreboard entry: saturating countdown of cycles until the register is forwardable.
// Clear beats hold, hold beats load/decrement.
module hazard_sb_cnt
  import hazard_pkg::*;
#(
  parameter int TW = HZ_TW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          hold,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - TW'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: per-register countdown scoreboard plus an XALU busy counter for HI/LO users.
// Hazards are evaluated against pre-issue state, so an instruction never stalls on its own destination.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int NSRC = 2,
  parameter int TW   = HZ_TW,
  parameter int XW   = HZ_XW
) (
  input  logic             clk,
  input  logic             resetn,
  hazard_scoreboard_if.slave dec,
  input  logic             pipe_hold,
  input  logic             exp_flush,
  output logic             xalu_busy,
  output logic [NREG-1:0]  sb_pending
);

  logic [NREG-1:0][TW-1:0] cnt;
  logic [XW-1:0]           xalu_cnt;
  logic                    haz_src;
  logic                    haz_x;
  logic [RW-1:0]           src;
  logic [TW-1:0]           tuse;
  logic                    dst_load;
  logic [TW-1:0]           dst_load_val;

  assign cnt[0] = '0;

  // The -1 covers the producer moving one stage on before the consumer sits in decode.
  assign dst_load     = dec.issue && dec.id_dst_we && (dec.id_dst_reg != '0);
  assign dst_load_val = dec.id_dst_tnew - TW'(1);

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    hazard_sb_cnt #(.TW(TW)) u_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (exp_flush),
      .hold     (pipe_hold),
      .load     (dst_load && (dec.id_dst_reg == RW'(r))),
      .load_val (dst_load_val),
      .cnt      (cnt[r])
    );
  end

  always_comb begin
    haz_src = 1'b0;
    src     = '0;
    tuse    = '0;
    for (int k = 0; k < NSRC; k++) begin
      src  = dec.id_src_reg[k*RW +: RW];
      tuse = dec.id_src_tuse[k*TW +: TW];
      if (dec.id_src_need[k] && (src != '0) && (cnt[src] > tuse)) begin
        haz_src = 1'b1;
      end
    end
  end

  assign haz_x     = dec.id_hilo_use && (xalu_cnt != '0);
  assign dec.stall = dec.id_valid && (haz_src || haz_x) && !exp_flush;
  assign dec.issue = dec.id_valid && !dec.stall && !pipe_hold && !exp_flush;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      sb_pending[r] = (cnt[r] != '0);
    end
  end

  // XALU runs on its own clock of work: freezes and flushes do not pause or cancel it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xalu_cnt <= '0;
    end else if (dec.issue && dec.id_xalu_start) begin
      xalu_cnt <= dec.id_xalu_lat;
    end else if (xalu_cnt != '0) begin
      xalu_cnt <= xalu_cnt - XW'(1);
    end
  end

  assign xalu_busy = (xalu_cnt != '0);

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage Tuse/Tnew stall logic.
- Replaces fixed D/E-stage comparisons with a per-register countdown scoreboard. One entry per architectural register; each entry holds the cycles remaining until that register's value is forwardable.
- Adds an internal XALU (mult/div) busy counter, so the HI/LO interlock no longer depends on an external busy signal.
- Sits beside the decode stage. Produces `stall` and `issue` for the D/E pipeline register.

Parameters:
- NREG, 32: number of architectural GPRs. Register 0 is never tracked.
- RW, 5: register-id width, equal to clog2(NREG).
- NSRC, 2: source operands checked per decoded instruction.
- TW, 3: width of Tuse/Tnew fields and of each scoreboard counter.
- XW, 6: width of the XALU latency counter.

Ports:
- clk, in, 1: clock.
- resetn, in, 1: asynchronous active-low reset.
- id_valid, in, 1: decode stage holds a valid instruction.
- id_src_reg, in, NSRC*RW: source register ids, operand k at bits [k*RW +: RW].
- id_src_need, in, NSRC: operand k is read.
- id_src_tuse, in, NSRC*TW: Tuse of operand k (0 = branch compare, 1 = ALU, 2 = store data / mtc0).
- id_dst_we, in, 1: instruction writes a GPR.
- id_dst_reg, in, RW: destination register.
- id_dst_tnew, in, TW: Tnew of the result (2 = ALU, 3 = load/mfc0, 4 = lwl/lwr). Must be 1 or greater.
- id_hilo_use, in, 1: instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- id_xalu_start, in, 1: instruction starts a multicycle XALU operation.
- id_xalu_lat, in, XW: busy cycles for that operation.
- pipe_hold, in, 1: global freeze (memory wait). Nothing advances.
- exp_flush, in, 1: exception/eret flush.
- stall, out, 1: decode must hold.
- issue, out, 1: instruction advances into E this cycle.
- xalu_busy, out, 1: XALU counter is nonzero.
- sb_pending, out, NREG: bit r is set when cnt[r] != 0. Bit 0 is always 0. Used for debug and assertions.

Behaviour:
- Reset (asynchronous, resetn = 0): all cnt[r] = 0, xalu_cnt = 0. Outputs are then stall = 0, issue = 0, xalu_busy = 0, sb_pending = 0.
- Per-operand hazard: haz_k = id_src_need[k] && src_k != 0 && cnt[src_k] > tuse_k.
- XALU hazard: haz_x = id_hilo_use && xalu_cnt != 0.
- stall = id_valid && (OR of haz_k || haz_x) && !exp_flush. This is combinational from registered state plus decode inputs, with zero latency.
- issue = id_valid && !stall && !pipe_hold && !exp_flush.
- Register counter update, only when pipe_hold = 0:
  - Every nonzero cnt[r] decrements by 1, saturating at 0.
  - If issue && id_dst_we && id_dst_reg != 0, then cnt[dst] <= id_dst_tnew - 1. This write overrides the decrement for that entry.
  - The -1 accounts for the producer advancing one stage before its consumer reaches decode.
- pipe_hold = 1: all cnt frozen, issue = 0, stall still computed.
- exp_flush = 1: every cnt cleared to 0 on the next edge, with priority over issue and hold. Forces stall = 0 and issue = 0 that cycle.
- Self-dependency (a source equals the destination): sources are checked against pre-issue state. The instruction never stalls on itself.
- WAW to the same register: the younger issue overwrites the entry, even when the younger Tnew is smaller. Forwarding always selects the youngest value.
- XALU counter:
  - Decrements every cycle when nonzero, independent of pipe_hold and exp_flush.
  - On issue && id_xalu_start: xalu_cnt <= id_xalu_lat, overriding the decrement.
  - A start with id_xalu_lat = 0 leaves xalu_cnt at 0.
  - xalu_busy = (xalu_cnt != 0).
- Back-to-back mult: the second mult has id_hilo_use = 1, so it stalls for xalu_cnt cycles. No separate E-stage check is needed.
- Mid-operation reset: all state clears immediately; no pending hazard survives.

Decomposition:
- hazard_pkg holds TW/XW defaults and the named constants:
  - TUSE_BR = 0, TUSE_ALU = 1, TUSE_ST = 2
  - TNEW_ALU = 2, TNEW_LD = 3, TNEW_LWLR = 4
  - XALU_MUL_LAT, XALU_DIV_LAT
  - The decode unit uses the same constants.
- One sub-module, hazard_sb_cnt: a single TW-bit saturating countdown with load, hold and clear, instantiated for registers 1..NREG-1. Comparators and the OR tree stay in the top level.

Test Plan:
- Load-use: lw r5 (tnew 3), then add r6,r5 (tuse 1) → stall for 1 cycle, issue on the 2nd cycle. sb_pending[5] = 1 for 2 cycles.
- Load then branch: lw r5, then beq r5 (tuse 0) → 2 stall cycles. With pipe_hold = 1 held for 3 cycles in between, the stall lengthens by exactly 3 and cnt[5] stays frozen.
- ALU then store: addu r7 (tnew 2), then sw r7 data (tuse 2) → no stall. addu r7 then beq r7 → 1 stall.
- WAW/self: lwl r8 (tnew 4), then addu r8,r8 (tuse 1) → 2 stall cycles, then cnt[8] = 1. Next consumer with tuse 0 → 1 stall.
- XALU: div with id_xalu_lat = 32, then mflo → stall for exactly 32 cycles; xalu_busy falls together with the stall. Writes to r0 never set sb_pending[0].
- Flush/reset: lw r9 issued, then exp_flush → cnt cleared, next add r9 has no stall, xalu_cnt keeps counting. Asserting resetn = 0 mid-divide → xalu_busy = 0 immediately.
